// File: rtl/reg_checkpoint_pkg.sv
// Shared types for the register checkpoint unit: FSM state encoding and
// the register index type for the default 32-entry register file.
package reg_checkpoint_pkg;

  localparam int NUM_REGS_DEF   = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH     = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RESTORE = 2'd2
  } ckpt_state_e;

endpackage

// File: rtl/reg_checkpoint_if.sv
// Bundle between the hazard controller / register file (master) and the
// checkpoint unit (slave). Requests are level-sampled on every clk edge; the
// done outputs are one-cycle pulses; there is no backpressure.
interface reg_checkpoint_if
  import reg_checkpoint_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
);
  logic                  take_snapshot;
  logic [DATA_WIDTH-1:0] regs_in [NUM_REGS];
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  recover;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rs_done;
  logic                  recovery_done;
  logic                  snapshot_valid;
  logic                  busy;
  ckpt_state_e           state;

  modport master (
    output take_snapshot, regs_in, wb_we, wb_addr, recover,
    input  rf_we, rf_addr, rf_data, rs_done, recovery_done, snapshot_valid, busy, state
  );

  modport slave (
    input  take_snapshot, regs_in, wb_we, wb_addr, recover,
    output rf_we, rf_addr, rf_data, rs_done, recovery_done, snapshot_valid, busy, state
  );
endinterface

// File: rtl/reg_checkpoint_unit_lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit of mask,
// never reporting bit 0 (r0 is hardwired zero and never restored).
module lowest_set_idx #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]   mask,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  any
);
  logic unused_bit0;
  assign unused_bit0 = mask[0];

  always_comb begin
    idx = '0;
    // Scan downward so the last hit, the lowest index, wins.
    for (int i = NUM_REGS - 1; i >= 1; i--) begin
      if (mask[i]) idx = ADDR_WIDTH'(i);
    end
    any = |mask[NUM_REGS-1:1];
  end
endmodule

// File: rtl/reg_checkpoint_unit.sv
// Register file checkpoint/restore responder. With REG_CHECKPOINT_DIRTY_TRACK_EN
// only registers written since the checkpoint are replayed; otherwise all of r1..rN-1.
module reg_checkpoint_unit
  import reg_checkpoint_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input logic             clk,
  input logic             rst_n,
  reg_checkpoint_if.slave bus
);
  localparam logic [NUM_REGS-1:0] ALL_REGS = {{(NUM_REGS-1){1'b1}}, 1'b0};

  ckpt_state_e           state_q, state_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic                  rs_done_q, rs_done_d;
  logic                  rec_done_q, rec_done_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  cap;
  logic [DATA_WIDTH-1:0] snap_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   enc_mask;
  logic [ADDR_WIDTH-1:0] enc_idx;
  logic                  enc_any;

  logic unused_r0;
  assign unused_r0 = ^bus.regs_in[0];
`ifndef REG_CHECKPOINT_DIRTY_TRACK_EN
  logic unused_wb;
  assign unused_wb = ^{bus.wb_we, bus.wb_addr};
`endif

  // pend_q holds the registers still to be replayed; in HELD it is the dirty mask.
  always_comb begin
`ifdef REG_CHECKPOINT_DIRTY_TRACK_EN
    enc_mask = pend_q;
`else
    enc_mask = (state_q == RESTORE) ? pend_q : ALL_REGS;
`endif
  end

  lowest_set_idx #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_enc (
    .mask (enc_mask),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = '0;
    rf_data_d  = '0;
    rs_done_d  = 1'b0;
    rec_done_d = 1'b0;
    valid_d    = valid_q;
    cap        = 1'b0;
    if ((state_q == RESTORE || (state_q == HELD && bus.recover)) && enc_any) begin
      state_d   = RESTORE;
      rf_we_d   = 1'b1;
      rf_addr_d = enc_idx;
      rf_data_d = snap_q[enc_idx];
      pend_d    = enc_mask & ~(NUM_REGS'(1) << enc_idx);
    end else if (state_q == RESTORE || bus.recover) begin
      // Recover with nothing left to write (or nothing held) completes here.
      state_d    = IDLE;
      pend_d     = '0;
      rec_done_d = 1'b1;
      valid_d    = 1'b0;
    end else begin
      if (bus.take_snapshot) begin
        cap       = 1'b1;
        state_d   = HELD;
        pend_d    = '0;
        rs_done_d = 1'b1;
        valid_d   = 1'b1;
      end
`ifdef REG_CHECKPOINT_DIRTY_TRACK_EN
      // A same-cycle write lands after the capture, so it still marks dirty.
      if (bus.wb_we && bus.wb_addr != '0 && (state_q == HELD || bus.take_snapshot))
        pend_d[bus.wb_addr] = 1'b1;
`endif
    end
    busy_d = (state_d == RESTORE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      rs_done_q  <= 1'b0;
      rec_done_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      rs_done_q  <= rs_done_d;
      rec_done_q <= rec_done_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Checkpoint storage is deliberately not reset; it is only read while valid.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 1; i < NUM_REGS; i++) snap_q[i] <= bus.regs_in[i];
    end
  end

  assign bus.rf_we          = rf_we_q;
  assign bus.rf_addr        = rf_addr_q;
  assign bus.rf_data        = rf_data_q;
  assign bus.rs_done        = rs_done_q;
  assign bus.recovery_done  = rec_done_q;
  assign bus.snapshot_valid = valid_q;
  assign bus.busy           = busy_q;
  assign bus.state          = state_q;
endmodule
